nibble_serial_add_ctrl: RTL

//  Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one external 4-bit ripple-carry

---
 rtl/nibble_serial_add_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl
// Brief    : WIDTH-bit add/subtract sequenced LSB-nibble-first through one
//            shared external 4-bit combinational adder slice.
// Revision : 1.0  initial release
// ============================================================================
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic [3:0]       sl_a,
    output logic [3:0]       sl_b,
    output logic             sl_cin,
    input  logic [3:0]       sl_s,
    input  logic             sl_cout
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_bx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_a_sh;
    logic [WIDTH-1:0]   w_b_sh;

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_last   = (r_idx == LAST_IDX);
    assign w_a_sh   = r_a  >> {r_idx, 2'b00};
    assign w_b_sh   = r_bx >> {r_idx, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        sl_a        = 4'd0;
        sl_b        = 4'd0;
        sl_cin      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                sl_a   = w_a_sh[3:0];
                sl_b   = w_b_sh[3:0];
                sl_cin = r_carry;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted at capture and carry seeded to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_bx    <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= op_a;
                r_bx    <= op_sub ? ~op_b : op_b;
                r_carry <= op_sub ? 1'b1 : carry_in;
                r_idx   <= '0;
            end else if (r_state == ST_RUN) begin
                r_sum[{r_idx, 2'b00} +: 4] <= sl_s;
                r_carry <= sl_cout;
                if (w_last) begin
                    r_idx  <= '0;
                    r_cout <= sl_cout;
                    r_ovf  <= (r_a[WIDTH-1] == r_bx[WIDTH-1]) && (sl_s[3] != r_a[WIDTH-1]);
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire
